// File: rtl/dma_nios2_debug_pkg.sv
// Shared types and jdo field positions for the OCI debug-memory engine.
package dma_nios2_debug_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StRdReq,
    StRdData,
    StWrReq
  } state_e;

  localparam int unsigned JDO_ADDR_LSB   = 10;
  localparam int unsigned JDO_DATA_LSB   = 3;
  localparam int unsigned JDO_RDFLAG     = 34;
  localparam int unsigned DEFAULT_ADDR_W = 8;

endpackage

// File: rtl/dma_nios2_gen2_0_cpu_debug_mem_engine.sv
// Executes OCI debug-memory load/read/write commands against the debug RAM over Avalon-MM.
module dma_nios2_gen2_0_cpu_debug_mem_engine
  import dma_nios2_debug_pkg::*;
#(
  parameter int unsigned ADDR_W = DEFAULT_ADDR_W,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [37:0]       jdo,
  input  logic              take_action_ocimem_a,
  input  logic              take_no_action_ocimem_a,
  input  logic              take_action_ocimem_b,
  output logic [ADDR_W-1:0] avm_address,
  output logic              avm_read,
  output logic              avm_write,
  output logic [DATA_W-1:0] avm_writedata,
  input  logic [DATA_W-1:0] avm_readdata,
  input  logic              avm_waitrequest,
  output logic [DATA_W-1:0] MonDReg,
  output logic              monitor_ready,
  output logic              monitor_error
);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [ADDR_W-1:0]   avm_addr_q, avm_addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   mon_q, mon_d;
  logic                read_q, read_d;
  logic                write_q, write_d;
  logic                ready_q, ready_d;
  logic                error_q, error_d;

  logic                win_a, win_na, win_b, collide, addr_inc;
  logic [ADDR_W-1:0]   jdo_addr;
  logic [DATA_W-1:0]   jdo_data;
  logic                unused_jdo;

  assign jdo_addr   = jdo[JDO_ADDR_LSB +: ADDR_W];
  assign jdo_data   = jdo[JDO_DATA_LSB +: DATA_W];
  assign unused_jdo = ^{jdo[37:35], jdo[2:0]};

  // Only an idle engine accepts a command; every other strobe is a loser and flags an error.
  always_comb begin
    win_a   = 1'b0;
    win_na  = 1'b0;
    win_b   = 1'b0;
    collide = 1'b0;
    if (state_q == StIdle) begin
      win_a   = take_action_ocimem_a;
      win_na  = take_no_action_ocimem_a & ~take_action_ocimem_a;
      win_b   = take_action_ocimem_b & ~take_action_ocimem_a & ~take_no_action_ocimem_a;
      collide = (take_action_ocimem_a & take_no_action_ocimem_a) |
                (take_action_ocimem_a & take_action_ocimem_b) |
                (take_no_action_ocimem_a & take_action_ocimem_b);
    end else begin
      collide = take_action_ocimem_a | take_no_action_ocimem_a | take_action_ocimem_b;
    end
    error_d = collide | (error_q & ~win_a);
  end

  always_comb begin
    addr_d = addr_q;
    if (win_a) begin
      addr_d = jdo_addr;
    end else if (addr_inc) begin
      addr_d = addr_q + ADDR_W'(1);
    end
  end

  always_comb begin
    state_d    = state_q;
    read_d     = read_q;
    write_d    = write_q;
    avm_addr_d = avm_addr_q;
    wdata_d    = wdata_q;
    mon_d      = mon_q;
    addr_inc   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (win_a && jdo[JDO_RDFLAG]) begin
          state_d    = StRdReq;
          read_d     = 1'b1;
          avm_addr_d = jdo_addr;
        end else if (win_na) begin
          state_d    = StRdReq;
          read_d     = 1'b1;
          avm_addr_d = addr_q;
        end else if (win_b) begin
          state_d    = StWrReq;
          write_d    = 1'b1;
          avm_addr_d = addr_q;
          wdata_d    = jdo_data;
        end
      end
      StRdReq: begin
        if (!avm_waitrequest) begin
          read_d  = 1'b0;
          state_d = StRdData;
        end
      end
      StRdData: begin
        mon_d    = avm_readdata;
        addr_inc = 1'b1;
        state_d  = StIdle;
      end
      StWrReq: begin
        if (!avm_waitrequest) begin
          write_d  = 1'b0;
          mon_d    = wdata_q;
          addr_inc = 1'b1;
          state_d  = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
    ready_d = (state_d == StIdle);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      addr_q     <= '0;
      avm_addr_q <= '0;
      wdata_q    <= '0;
      mon_q      <= '0;
      read_q     <= 1'b0;
      write_q    <= 1'b0;
      ready_q    <= 1'b1;
      error_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      avm_addr_q <= avm_addr_d;
      wdata_q    <= wdata_d;
      mon_q      <= mon_d;
      read_q     <= read_d;
      write_q    <= write_d;
      ready_q    <= ready_d;
      error_q    <= error_d;
    end
  end

  assign avm_address   = avm_addr_q;
  assign avm_read      = read_q;
  assign avm_write     = write_q;
  assign avm_writedata = wdata_q;
  assign MonDReg       = mon_q;
  assign monitor_ready = ready_q;
  assign monitor_error = error_q;

endmodule

// File: tb/tb_dma_nios2_gen2_0_cpu_debug_mem_engine.sv
// Directed bench for the OCI debug-memory engine with a behavioural 1-cycle-latency RAM.
module tb_dma_nios2_gen2_0_cpu_debug_mem_engine;

  logic        clk = 1'b0;
  logic        reset;
  logic [37:0] jdo;
  logic        st_a, st_na, st_b;
  logic [7:0]  avm_address;
  logic        avm_read, avm_write;
  logic [31:0] avm_writedata;
  logic [31:0] avm_readdata = '0;
  logic        avm_waitrequest;
  logic [31:0] MonDReg;
  logic        monitor_ready, monitor_error;

  int          vectors = 0;
  int          miscompares = 0;
  int          wr_cnt = 0;
  logic [7:0]  wr_addr [8];
  logic [31:0] wr_data [8];

  always #5 clk = ~clk;

  dma_nios2_gen2_0_cpu_debug_mem_engine dut (
    .clk                     (clk),
    .reset                   (reset),
    .jdo                     (jdo),
    .take_action_ocimem_a    (st_a),
    .take_no_action_ocimem_a (st_na),
    .take_action_ocimem_b    (st_b),
    .avm_address             (avm_address),
    .avm_read                (avm_read),
    .avm_write               (avm_write),
    .avm_writedata           (avm_writedata),
    .avm_readdata            (avm_readdata),
    .avm_waitrequest         (avm_waitrequest),
    .MonDReg                 (MonDReg),
    .monitor_ready           (monitor_ready),
    .monitor_error           (monitor_error)
  );

  function automatic logic [31:0] ram_word(input logic [7:0] a);
    return (a == 8'h10) ? 32'hDEADBEEF : {24'hC0FFEE, a};
  endfunction

  // RAM: read data one cycle after acceptance; writes are logged.
  always @(posedge clk) begin
    if (avm_read && !avm_waitrequest) avm_readdata <= ram_word(avm_address);
    if (avm_write && !avm_waitrequest) begin
      wr_addr[wr_cnt[2:0]] <= avm_address;
      wr_data[wr_cnt[2:0]] <= avm_writedata;
      wr_cnt <= wr_cnt + 1;
    end
  end

  function automatic logic [37:0] mk_load(input logic [7:0] a, input logic rd);
    logic [37:0] j;
    j = '0;
    j[17:10] = a;
    j[34] = rd;
    return j;
  endfunction

  function automatic logic [37:0] mk_write(input logic [31:0] d);
    logic [37:0] j;
    j = '0;
    j[34:3] = d;
    return j;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [7:0] ea;
    logic       stable;
    reset = 1'b1; jdo = '0; st_a = 0; st_na = 0; st_b = 0; avm_waitrequest = 0;
    step(); step();
    chk("rst_ready", monitor_ready, 1);
    chk("rst_error", monitor_error, 0);
    chk("rst_mon", MonDReg, 0);
    chk("rst_read", avm_read, 0);
    chk("rst_write", avm_write, 0);
    chk("rst_addr", avm_address, 0);
    chk("rst_wdata", avm_writedata, 0);
    reset = 1'b0;
    step();

    // Load with read at 0x10.
    jdo = mk_load(8'h10, 1'b1); st_a = 1;
    step(); st_a = 0; jdo = '0;
    chk("ldrd_read_c1", avm_read, 1);
    chk("ldrd_addr_c1", avm_address, 32'h10);
    chk("ldrd_ready_c1", monitor_ready, 0);
    step();
    chk("ldrd_ready_c2", monitor_ready, 0);
    step();
    chk("ldrd_mon_c3", MonDReg, 32'hDEADBEEF);
    chk("ldrd_ready_c3", monitor_ready, 1);
    st_na = 1;
    step(); st_na = 0;
    chk("stream_addr17", avm_address, 32'h11);
    chk("stream_read", avm_read, 1);
    step(); step();
    chk("stream_mon", MonDReg, 32'hC0FFEE11);

    // Plain load 255, then writes wrapping through 0.
    jdo = mk_load(8'hFF, 1'b0); st_a = 1;
    step(); st_a = 0;
    chk("plain_ready", monitor_ready, 1);
    chk("plain_noread", avm_read, 0);
    for (int i = 0; i < 3; i++) begin
      ea = 8'hFF + 8'(i);
      jdo = mk_write(32'(i + 1)); st_b = 1;
      step(); st_b = 0; jdo = '0;
      chk("wr_req", avm_write, 1);
      chk("wr_addr", avm_address, 32'(ea));
      chk("wr_data", avm_writedata, 32'(i + 1));
      step();
      chk("wr_ready_c2", monitor_ready, 1);
      step(); step();
    end
    chk("wr_mon", MonDReg, 3);
    chk("wr_count", wr_cnt, 3);
    chk("wr_log0", wr_addr[0], 32'hFF);
    chk("wr_log1", wr_addr[1], 0);
    chk("wr_log2", wr_addr[2], 1);
    chk("wr_log2d", wr_data[2], 3);

    // Read stalled by 5 waitrequest cycles at address 2.
    avm_waitrequest = 1; st_na = 1;
    step(); st_na = 0;
    stable = 1'b1;
    for (int k = 0; k < 5; k++) begin
      if (!(avm_read === 1'b1 && avm_address === 8'h02)) stable = 1'b0;
      step();
    end
    avm_waitrequest = 0;
    if (!(avm_read === 1'b1 && avm_address === 8'h02)) stable = 1'b0;
    chk("stall_stable", 32'(stable), 1);
    step();
    chk("stall_read_c7", avm_read, 0);
    chk("stall_ready_c7", monitor_ready, 0);
    step();
    chk("stall_mon_c8", MonDReg, 32'hC0FFEE02);
    chk("stall_ready_c8", monitor_ready, 1);

    // Write strobe while a read is in flight is dropped.
    st_na = 1;
    step(); st_na = 0;
    jdo = mk_write(32'h55); st_b = 1;
    step(); st_b = 0; jdo = '0;
    chk("ovr_error", monitor_error, 1);
    chk("ovr_nowrite", avm_write, 0);
    step();
    chk("ovr_mon", MonDReg, 32'hC0FFEE03);
    step(); step();
    chk("ovr_wrcnt", wr_cnt, 3);
    chk("ovr_error_sticky", monitor_error, 1);
    jdo = mk_load(8'h20, 1'b0); st_a = 1;
    step(); st_a = 0;
    chk("ovr_clear", monitor_error, 0);

    // Simultaneous plain load (address 5) and write.
    jdo = mk_load(8'h05, 1'b0); st_a = 1; st_b = 1;
    step(); st_a = 0; st_b = 0; jdo = '0;
    chk("sim_error", monitor_error, 1);
    chk("sim_nowrite", avm_write, 0);
    step();
    chk("sim_wrcnt", wr_cnt, 3);
    st_na = 1;
    step(); st_na = 0;
    chk("sim_addr5", avm_address, 5);
    step(); step();
    chk("sim_mon", MonDReg, 32'hC0FFEE05);

    // Reset while the read at address 6 is stalled.
    avm_waitrequest = 1; st_na = 1;
    step(); st_na = 0;
    chk("rstmid_read_c1", avm_read, 1);
    chk("rstmid_addr_c1", avm_address, 6);
    reset = 1;
    step(); reset = 0; avm_waitrequest = 0;
    chk("rstmid_read", avm_read, 0);
    chk("rstmid_mon", MonDReg, 0);
    chk("rstmid_ready", monitor_ready, 1);
    chk("rstmid_error", monitor_error, 0);
    step(); step();
    chk("rstmid_mon_hold", MonDReg, 0);
    st_na = 1;
    step(); st_na = 0;
    chk("rstmid_addr0", avm_address, 0);
    step(); step();
    chk("rstmid_mon_rd0", MonDReg, 32'hC0FFEE00);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
